// File: rtl/ddr_cmd_sched.sv
// ddr_cmd_sched: four-requester DDR command scheduler.
// Arbitrates round-robin among the requesters and tracks the open row of each of
// the 16 banks. It issues PRE/ACT/RD/WR with fixed tRP/tRCD spacing and inserts
// PREA/REF every TREFI clocks.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/addr/write/wdata (in)  per-requester request, 32-bit lanes
//   req_ready (out)                  one-hot grant, combinational, IDLE only
//   cmd_* (out)                      registered command bus; cmd_type 000 = NOP
//
// State      | meaning
// IDLE       | waiting for a request or a due refresh
// PRE        | PRE to the latched bank (row conflict)
// PRE_WAIT   | tRP spacing before ACT
// ACT        | ACT with the latched row
// ACT_WAIT   | tRCD spacing before RD/WR
// RW         | RD or WR to the latched column
// PREA       | close all banks ahead of refresh
// PREA_WAIT  | tRP spacing before REF
// REF        | refresh command
// REF_WAIT   | tRFC spacing before returning to IDLE
module ddr_cmd_sched #(
  parameter int TRCD  = 3,
  parameter int TRP   = 3,
  parameter int TREFI = 200,
  parameter int TRFC  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req_valid,
  input  logic [127:0] req_addr,
  input  logic [3:0]   req_write,
  input  logic [127:0] req_wdata,
  output logic [3:0]   req_ready,
  output logic         cmd_valid,
  output logic [2:0]   cmd_type,
  output logic [1:0]   cmd_bg,
  output logic [1:0]   cmd_ba,
  output logic [14:0]  cmd_row,
  output logic [9:0]   cmd_col,
  output logic [31:0]  cmd_wdata,
  output logic [1:0]   cmd_id
);

  localparam logic [2:0] C_NOP = 3'b000, C_ACT = 3'b001, C_RD = 3'b010, C_WR = 3'b011,
                         C_PRE = 3'b100, C_PREA = 3'b101, C_REF = 3'b110;

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_PRE_WAIT, S_ACT, S_ACT_WAIT, S_RW,
    S_PREA, S_PREA_WAIT, S_REF, S_REF_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] ref_cnt_q, ref_cnt_d;
  logic        pend_q, pend_d;
  logic [1:0]  last_q, last_d;
  logic [15:0] open_q, open_d;
  logic [14:0] row_q [16];
  logic [14:0] row_d [16];
  logic [28:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  id_q, id_d;

  logic        cv_q, cv_d;
  logic [2:0]  ct_q, ct_d;
  logic [1:0]  cbg_q, cbg_d, cba_q, cba_d, cid_q, cid_d;
  logic [14:0] crow_q, crow_d;
  logic [9:0]  ccol_q, ccol_d;
  logic [31:0] cwd_q, cwd_d;

  logic        win_found, grant, ref_hit, refresh_req, cur_wr, unused_addr_bits;
  logic [1:0]  win_idx, cand, cur_id;
  logic [31:0] win_addr, win_wdata, cur_wdata;
  logic [28:0] cur_addr;
  logic [3:0]  cur_bank;

  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_addr         = req_addr[{win_idx, 5'd0} +: 32];
  assign win_wdata        = req_wdata[{win_idx, 5'd0} +: 32];
  assign unused_addr_bits = ^win_addr[31:29];

  // A refresh falling due this very cycle already blocks the grant.
  assign ref_hit     = (ref_cnt_q == 16'(TREFI - 1));
  assign refresh_req = pend_q | ref_hit;
  assign grant       = !rst && (state_q == S_IDLE) && !refresh_req && win_found;
  assign req_ready   = grant ? (4'b0001 << win_idx) : 4'b0000;

  // On the accept edge the decision must see the winner, not the stale latch.
  assign cur_addr  = grant ? win_addr[28:0] : addr_q;
  assign cur_wr    = grant ? req_write[win_idx] : wr_q;
  assign cur_wdata = grant ? win_wdata : wdata_q;
  assign cur_id    = grant ? win_idx : id_q;
  assign cur_bank  = cur_addr[28:25];

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE:
        if (refresh_req)       state_d = (|open_q) ? S_PREA : S_REF;
        else if (grant) begin
          if (!open_q[cur_bank])                       state_d = S_ACT;
          else if (row_q[cur_bank] == cur_addr[24:10]) state_d = S_RW;
          else                                         state_d = S_PRE;
        end
      S_PRE:       if (TRP > 1) begin state_d = S_PRE_WAIT; wait_d = 8'(TRP - 2); end
                   else state_d = S_ACT;
      S_PRE_WAIT:  if (wait_q == 8'd0) state_d = S_ACT; else wait_d = wait_q - 8'd1;
      S_ACT:       if (TRCD > 1) begin state_d = S_ACT_WAIT; wait_d = 8'(TRCD - 2); end
                   else state_d = S_RW;
      S_ACT_WAIT:  if (wait_q == 8'd0) state_d = S_RW; else wait_d = wait_q - 8'd1;
      S_RW:        state_d = S_IDLE;
      S_PREA:      if (TRP > 1) begin state_d = S_PREA_WAIT; wait_d = 8'(TRP - 2); end
                   else state_d = S_REF;
      S_PREA_WAIT: if (wait_q == 8'd0) state_d = S_REF; else wait_d = wait_q - 8'd1;
      S_REF:       if (TRFC > 1) begin state_d = S_REF_WAIT; wait_d = 8'(TRFC - 2); end
                   else state_d = S_IDLE;
      S_REF_WAIT:  if (wait_q == 8'd0) state_d = S_IDLE; else wait_d = wait_q - 8'd1;
      default:     state_d = S_IDLE;
    endcase
  end

  // Command and bank-table updates follow the state being entered, so each
  // command appears in the same cycle as its state.
  always_comb begin
    cv_d = 1'b0; ct_d = C_NOP; cbg_d = 2'd0; cba_d = 2'd0; crow_d = 15'd0;
    ccol_d = 10'd0; cwd_d = 32'd0; cid_d = 2'd0;
    open_d = open_q;
    row_d  = row_q;
    case (state_d)
      S_PRE: begin
        cv_d = 1'b1; ct_d = C_PRE; {cbg_d, cba_d} = cur_bank;
        open_d[cur_bank] = 1'b0;
      end
      S_ACT: begin
        cv_d = 1'b1; ct_d = C_ACT; {cbg_d, cba_d} = cur_bank; crow_d = cur_addr[24:10];
        open_d[cur_bank] = 1'b1;
        row_d[cur_bank]  = cur_addr[24:10];
      end
      S_RW: begin
        cv_d = 1'b1; ct_d = cur_wr ? C_WR : C_RD; {cbg_d, cba_d} = cur_bank;
        ccol_d = cur_addr[9:0]; cid_d = cur_id;
        cwd_d  = cur_wr ? cur_wdata : 32'd0;
      end
      S_PREA: begin cv_d = 1'b1; ct_d = C_PREA; open_d = 16'd0; end
      S_REF:  begin cv_d = 1'b1; ct_d = C_REF; end
      default: ;
    endcase
  end

  always_comb begin
    ref_cnt_d = ref_hit ? 16'd0 : ref_cnt_q + 16'd1;
    pend_d    = (state_d == S_REF) ? 1'b0 : (ref_hit ? 1'b1 : pend_q);
    last_d    = grant ? win_idx : last_q;
    addr_d    = grant ? win_addr[28:0] : addr_q;
    wr_d      = cur_wr;
    wdata_d   = cur_wdata;
    id_d      = cur_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;  wait_q <= 8'd0;  ref_cnt_q <= 16'd0; pend_q <= 1'b0;
      last_q  <= 2'd3;    open_q <= 16'd0; row_q <= '{default: 15'd0};
      addr_q  <= 29'd0;   wr_q <= 1'b0;    wdata_q <= 32'd0;   id_q <= 2'd0;
      cv_q <= 1'b0; ct_q <= C_NOP; cbg_q <= 2'd0; cba_q <= 2'd0; crow_q <= 15'd0;
      ccol_q <= 10'd0; cwd_q <= 32'd0; cid_q <= 2'd0;
    end else begin
      state_q <= state_d; wait_q <= wait_d; ref_cnt_q <= ref_cnt_d; pend_q <= pend_d;
      last_q  <= last_d;  open_q <= open_d; row_q <= row_d;
      addr_q  <= addr_d;  wr_q <= wr_d;     wdata_q <= wdata_d;   id_q <= id_d;
      cv_q <= cv_d; ct_q <= ct_d; cbg_q <= cbg_d; cba_q <= cba_d; crow_q <= crow_d;
      ccol_q <= ccol_d; cwd_q <= cwd_d; cid_q <= cid_d;
    end
  end

  assign cmd_valid = cv_q;
  assign cmd_type  = ct_q;
  assign cmd_bg    = cbg_q;
  assign cmd_ba    = cba_q;
  assign cmd_row   = crow_q;
  assign cmd_col   = ccol_q;
  assign cmd_wdata = cwd_q;
  assign cmd_id    = cid_q;

endmodule

// File: tb/tb_ddr_cmd_sched.sv
module tb_ddr_cmd_sched;
  logic         clk, rst;
  logic [3:0]   req_valid, req_write, req_ready;
  logic [127:0] req_addr, req_wdata;
  logic         cmd_valid;
  logic [2:0]   cmd_type;
  logic [1:0]   cmd_bg, cmd_ba, cmd_id;
  logic [14:0]  cmd_row;
  logic [9:0]   cmd_col;
  logic [31:0]  cmd_wdata;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  ddr_cmd_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_ready(req_ready),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_wdata(cmd_wdata), .cmd_id(cmd_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // clocks since the last reset edge; equals the refresh counter until it wraps
  always @(posedge clk) if (rst) cyc <= 0; else cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic w, input logic [31:0] d);
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_addr[i*32 +: 32]  = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; req_write = '0; req_addr = '0; req_wdata = '0;
    tick();
    tests++;
    if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    tick();
    tests++;
    if ({cmd_valid, cmd_type, cmd_bg, cmd_ba, cmd_row, cmd_col, cmd_wdata, cmd_id} !== '0) begin
      fails++; $display("FAIL reset_cmd: got v=%b t=%b row=%h col=%h wd=%h expected all zero",
                        cmd_valid, cmd_type, cmd_row, cmd_col, cmd_wdata);
    end
    rst = 1'b0; req_valid = '0;
  endtask

  task automatic test_miss();
    do_reset();
    set_req(0, 32'h0000_07E8, 1'b1, 32'h0000_00A5);
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin fails++; $display("FAIL miss_ready: got %b expected 0001", req_ready); end
    tick(); req_valid = '0;
    // 0x7E8 carries bit 10, so the row field is 1 and the column 0x3E8
    tests++;
    if ({cmd_valid, cmd_type, cmd_bg, cmd_ba, cmd_row} !== {1'b1, 3'b001, 2'd0, 2'd0, 15'd1}) begin
      fails++; $display("FAIL miss_act: got v=%b t=%b bg=%0d ba=%0d row=%h expected ACT bg0 ba0 row 1",
                        cmd_valid, cmd_type, cmd_bg, cmd_ba, cmd_row);
    end
    tests++;
    if (req_ready !== 4'b0000) begin fails++; $display("FAIL miss_ready_busy: got %b expected 0000", req_ready); end
    for (int k = 2; k <= 3; k++) begin
      tick();
      tests++;
      if (cmd_valid !== 1'b0 || cmd_type !== 3'b000) begin
        fails++; $display("FAIL miss_nop E+%0d: got v=%b t=%b expected NOP", k, cmd_valid, cmd_type);
      end
    end
    tick();
    tests++;
    if ({cmd_valid, cmd_type, cmd_col, cmd_wdata, cmd_id} !== {1'b1, 3'b011, 10'h3E8, 32'hA5, 2'd0}) begin
      fails++; $display("FAIL miss_wr: got v=%b t=%b col=%h wd=%h id=%0d expected WR col 3e8 wd a5 id 0",
                        cmd_valid, cmd_type, cmd_col, cmd_wdata, cmd_id);
    end
    tick();
    tests++;
    if (cmd_valid !== 1'b0) begin fails++; $display("FAIL miss_idle: got v=%b expected 0", cmd_valid); end
  endtask

  task automatic test_hit_conflict();
    set_req(0, 32'h0000_07E8, 1'b0, 32'h0);
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin fails++; $display("FAIL hit_ready: got %b expected 0001", req_ready); end
    tick(); req_valid = '0;
    tests++;
    if ({cmd_valid, cmd_type, cmd_col, cmd_id} !== {1'b1, 3'b010, 10'h3E8, 2'd0}) begin
      fails++; $display("FAIL hit_rd: got v=%b t=%b col=%h id=%0d expected RD col 3e8 id 0",
                        cmd_valid, cmd_type, cmd_col, cmd_id);
    end
    tick();
    set_req(0, 32'h0000_3C00, 1'b0, 32'h0);
    #1;
    tick(); req_valid = '0;
    tests++;
    if ({cmd_valid, cmd_type, cmd_bg, cmd_ba} !== {1'b1, 3'b100, 2'd0, 2'd0}) begin
      fails++; $display("FAIL conf_pre: got v=%b t=%b expected PRE bank 0", cmd_valid, cmd_type);
    end
    for (int k = 2; k <= 7; k++) begin
      tick();
      tests++;
      if (k == 4) begin
        if ({cmd_valid, cmd_type, cmd_row} !== {1'b1, 3'b001, 15'd15}) begin
          fails++; $display("FAIL conf_act: got v=%b t=%b row=%0d expected ACT row 15", cmd_valid, cmd_type, cmd_row);
        end
      end else if (k == 7) begin
        if ({cmd_valid, cmd_type, cmd_col, cmd_id} !== {1'b1, 3'b010, 10'd0, 2'd0}) begin
          fails++; $display("FAIL conf_rd: got v=%b t=%b col=%h expected RD col 0", cmd_valid, cmd_type, cmd_col);
        end
      end else if (cmd_valid !== 1'b0 || cmd_type !== 3'b000) begin
        fails++; $display("FAIL conf_nop E+%0d: got v=%b t=%b expected NOP", k, cmd_valid, cmd_type);
      end
    end
  endtask

  task automatic test_arbitration();
    logic [1:0] exp;
    bit found;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 32'(i) << 25, 1'b0, 32'h0);
    for (int n = 0; n < 5; n++) begin
      exp = 2'(n);
      found = 1'b0;
      #1;
      for (int t = 0; t < 20 && !found; t++) begin
        if (req_ready !== 4'b0000) found = 1'b1;
        else tick();
      end
      tests++;
      if (!found || $countones(req_ready) != 1 || req_ready !== (4'b0001 << exp)) begin
        fails++; $display("FAIL arb_grant %0d: got %b expected one-hot for requester %0d", n, req_ready, exp);
      end
      tick();
      for (int t = 0; t < 10 && cmd_type !== 3'b010; t++) tick();
      tests++;
      if (cmd_type !== 3'b010 || cmd_id !== exp) begin
        fails++; $display("FAIL arb_id %0d: got t=%b id=%0d expected RD id %0d", n, cmd_type, cmd_id, exp);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_refresh();
    do_reset();
    set_req(0, 32'h0000_0000, 1'b0, 32'h0); #1; tick(); req_valid = '0;
    repeat (4) tick();
    set_req(1, 32'h0A00_0000, 1'b0, 32'h0); #1; tick(); req_valid = '0;
    repeat (4) tick();
    for (int g = 0; g < 400 && cyc != 199; g++) tick();
    tests++;
    if (cyc != 199) begin fails++; $display("FAIL ref_wait: got cycle %0d expected 199", cyc); end
    set_req(2, 32'h0000_0000, 1'b1, 32'h0000_1234);
    #1;
    tests++;
    if (req_ready !== 4'b0000) begin fails++; $display("FAIL ref_beats_grant: got %b expected 0000", req_ready); end
    tick();
    tests++;
    if (cmd_valid !== 1'b1 || cmd_type !== 3'b101) begin
      fails++; $display("FAIL ref_prea: got v=%b t=%b expected PREA", cmd_valid, cmd_type);
    end
    tick(); tick(); tick();
    tests++;
    if (cmd_valid !== 1'b1 || cmd_type !== 3'b110) begin
      fails++; $display("FAIL ref_ref: got v=%b t=%b expected REF", cmd_valid, cmd_type);
    end
    for (int k = 1; k <= 7; k++) begin
      tick();
      tests++;
      if (req_ready !== 4'b0000 || cmd_valid !== 1'b0) begin
        fails++; $display("FAIL ref_hold REF+%0d: got ready=%b v=%b expected 0000 0", k, req_ready, cmd_valid);
      end
    end
    tick();
    tests++;
    if (req_ready !== 4'b0100) begin fails++; $display("FAIL ref_release: got %b expected 0100", req_ready); end
    tick(); req_valid = '0;
    tests++;
    if (cmd_type !== 3'b001 || cmd_row !== 15'd0) begin
      fails++; $display("FAIL ref_banks_closed: got t=%b row=%0d expected ACT row 0", cmd_type, cmd_row);
    end
  endtask

  task automatic test_refresh_inflight();
    do_reset();
    for (int g = 0; g < 400 && cyc != 197; g++) tick();
    set_req(3, 32'h0000_0400, 1'b1, 32'h0000_CAFE);
    #1;
    tests++;
    if (req_ready !== 4'b1000) begin fails++; $display("FAIL infl_ready: got %b expected 1000", req_ready); end
    tick(); req_valid = '0;
    tests++;
    if (cmd_type !== 3'b001) begin fails++; $display("FAIL infl_act: got t=%b expected ACT", cmd_type); end
    tick(); tick(); tick();
    tests++;
    if ({cmd_valid, cmd_type, cmd_id, cmd_wdata} !== {1'b1, 3'b011, 2'd3, 32'hCAFE}) begin
      fails++; $display("FAIL infl_wr: got v=%b t=%b id=%0d wd=%h expected WR id 3 wd cafe",
                        cmd_valid, cmd_type, cmd_id, cmd_wdata);
    end
    tick();
    set_req(0, 32'h0, 1'b0, 32'h0);
    #1;
    tests++;
    if (cmd_valid !== 1'b0 || req_ready !== 4'b0000) begin
      fails++; $display("FAIL infl_idle: got v=%b ready=%b expected 0 0000", cmd_valid, req_ready);
    end
    req_valid = '0;
    tick();
    tests++;
    if (cmd_type !== 3'b101) begin fails++; $display("FAIL infl_prea: got t=%b expected PREA", cmd_type); end
    tick(); tick(); tick();
    tests++;
    if (cmd_type !== 3'b110) begin fails++; $display("FAIL infl_ref: got t=%b expected REF", cmd_type); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 32'h0000_0000, 1'b0, 32'h0); #1; tick(); req_valid = '0;
    repeat (4) tick();
    set_req(0, 32'h0000_0800, 1'b0, 32'h0); #1; tick(); req_valid = '0;
    tests++;
    if (cmd_type !== 3'b100) begin fails++; $display("FAIL rstmid_pre: got t=%b expected PRE", cmd_type); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 3; k <= 6; k++) begin
      tests++;
      if (cmd_valid !== 1'b0 || cmd_type !== 3'b000) begin
        fails++; $display("FAIL rstmid_quiet E+%0d: got v=%b t=%b expected NOP", k, cmd_valid, cmd_type);
      end
      tick();
    end
    set_req(0, 32'h0000_0800, 1'b0, 32'h0);
    #1;
    tick(); req_valid = '0;
    tests++;
    if (cmd_type !== 3'b001 || cmd_row !== 15'd2) begin
      fails++; $display("FAIL rstmid_miss: got t=%b row=%0d expected ACT row 2", cmd_type, cmd_row);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected end of tests");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    test_reset();
    test_miss();
    test_hit_conflict();
    test_arbitration();
    test_refresh();
    test_refresh_inflight();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
